// File: rtl/gcd_sched_pkg.sv
// Shared types for the GCD job scheduler: FSM states, response record and
// the default watchdog limit.
package gcd_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RESP = 2'd2
  } gcd_sched_state_e;

  localparam int GCD_DEF_TIMEOUT = 1024;

  // Response fields are sized for the widest supported instance
  // (up to 256 requesters, 64-bit operands); unused upper bits stay zero.
  localparam int GCD_RSP_ID_MAX_W   = 8;
  localparam int GCD_RSP_DATA_MAX_W = 64;

  typedef struct packed {
    logic [GCD_RSP_ID_MAX_W-1:0]   id;
    logic [GCD_RSP_DATA_MAX_W-1:0] result;
    logic                          error;
  } gcd_rsp_t;

endpackage

// File: rtl/gcd_rr_arbiter.sv
// Combinational rotating-priority picker: first set request at or above the
// pointer, wrapping around, as a one-hot grant plus its index.
module gcd_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    gnt_idx_o
);

  // Scan from the lowest priority to the highest so the nearest request
  // to the pointer is the one left standing.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin : g_scan
      int idx;
      idx = int'(ptr_i) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_i[idx[ID_W-1:0]]) begin
        gnt_o                   = '0;
        gnt_o[idx[ID_W-1:0]]    = 1'b1;
        gnt_idx_o               = idx[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/gcd_scheduler.sv
// Shares one iterative GCD engine among NUM_REQ requesters: round-robin
// accept, zero-operand bypass, watchdog abort, tagged single response port.
module gcd_scheduler
  import gcd_sched_pkg::*;
#(
  parameter  int NUM_REQ        = 4,
  parameter  int DATA_WIDTH     = 8,
  parameter  int TIMEOUT_CYCLES = GCD_DEF_TIMEOUT,
  localparam int ID_W           = $clog2(NUM_REQ)
) (
  input  logic                          clk_i,
  input  logic                          nreset_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [ID_W-1:0]               rsp_id_o,
  output logic [DATA_WIDTH-1:0]         rsp_result_o,
  output logic                          rsp_error_o,
  output logic                          eng_enable_o,
  output logic [DATA_WIDTH-1:0]         eng_a_o,
  output logic [DATA_WIDTH-1:0]         eng_b_o,
  input  logic                          eng_done_i,
  input  logic [DATA_WIDTH-1:0]         eng_result_i,
  output logic                          busy_o
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  gcd_sched_state_e        state_q, state_d;
  logic [ID_W-1:0]         ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WD_W-1:0]         wdog_q, wdog_d;
  gcd_rsp_t                rsp_q, rsp_d;

  logic [NUM_REQ-1:0]      gnt;
  logic [ID_W-1:0]         gnt_idx;
  logic [DATA_WIDTH-1:0]   sel_a, sel_b;
  logic [ID_W-1:0]         cur_id;

  gcd_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i     (req_valid_i),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign sel_a  = req_a_i[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
  assign sel_b  = req_b_i[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
  assign cur_id = rsp_q.id[ID_W-1:0];

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    a_d         = a_q;
    b_d         = b_q;
    wdog_d      = wdog_q;
    rsp_d       = rsp_q;
    req_ready_o = '0;
    case (state_q)
      ST_IDLE: begin
        req_ready_o = gnt;
        if (|req_valid_i) begin
          a_d                            = sel_a;
          b_d                            = sel_b;
          rsp_d.id                       = '0;
          rsp_d.id[ID_W-1:0]             = gnt_idx;
          rsp_d.error                    = 1'b0;
          if (sel_a == '0 || sel_b == '0) begin
            // gcd(x,0) = x and gcd(0,0) = 0, so no engine pass is needed.
            rsp_d.result                 = '0;
            rsp_d.result[DATA_WIDTH-1:0] = sel_a | sel_b;
            state_d                      = ST_RESP;
          end else begin
            wdog_d  = '0;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (eng_done_i) begin
          rsp_d.result                 = '0;
          rsp_d.result[DATA_WIDTH-1:0] = eng_result_i;
          rsp_d.error                  = 1'b0;
          state_d                      = ST_RESP;
        end else if (wdog_q == WD_LAST) begin
          rsp_d.result = '0;
          rsp_d.error  = 1'b1;
          state_d      = ST_RESP;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          ptr_d   = (cur_id == ID_W'(NUM_REQ - 1)) ? '0 : cur_id + ID_W'(1);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      wdog_q  <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      wdog_q  <= wdog_d;
      rsp_q   <= rsp_d;
    end
  end

  assign rsp_valid_o  = (state_q == ST_RESP);
  assign rsp_id_o     = cur_id;
  assign rsp_result_o = rsp_q.result[DATA_WIDTH-1:0];
  assign rsp_error_o  = rsp_q.error;
  assign eng_enable_o = (state_q == ST_RUN);
  assign eng_a_o      = a_q;
  assign eng_b_o      = b_q;
  assign busy_o       = (state_q != ST_IDLE);

  // Upper response bits beyond this instance's widths are constant zero.
  logic unused_rsp_hi;
  assign unused_rsp_hi = &{1'b0, rsp_q};

endmodule

// File: tb/tb_gcd_scheduler.sv
// Bench for gcd_scheduler: per-cycle compare against a job-level model plus
// directed scenarios with hand-computed expectations.
module tb_gcd_scheduler;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 16;
  localparam int CP = 10;

  logic           clk_i = 1'b0;
  logic           nreset_i = 1'b1;
  logic [N-1:0]   req_valid_i = '0;
  logic [N-1:0]   req_ready_o;
  logic [N*W-1:0] req_a_i = '0;
  logic [N*W-1:0] req_b_i = '0;
  logic           rsp_valid_o;
  logic           rsp_ready_i = 1'b1;
  logic [1:0]     rsp_id_o;
  logic [W-1:0]   rsp_result_o;
  logic           rsp_error_o;
  logic           eng_enable_o;
  logic [W-1:0]   eng_a_o, eng_b_o;
  logic           eng_done_i = 1'b0;
  logic [W-1:0]   eng_result_i = '0;
  logic           busy_o;

  gcd_scheduler #(.NUM_REQ(N), .DATA_WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .nreset_i(nreset_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_a_i(req_a_i), .req_b_i(req_b_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_id_o(rsp_id_o), .rsp_result_o(rsp_result_o), .rsp_error_o(rsp_error_o),
    .eng_enable_o(eng_enable_o), .eng_a_o(eng_a_o), .eng_b_o(eng_b_o),
    .eng_done_i(eng_done_i), .eng_result_i(eng_result_i), .busy_o(busy_o)
  );

  always #(CP/2) clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] gcd_f(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a; y = b;
    while (y != 0) begin t = x % y; x = y; y = t; end
    return x;
  endfunction

  // Per-requester job FIFOs; main pushes, driver pops on handshake.
  logic [W-1:0] ja[N][8];
  logic [W-1:0] jb[N][8];
  int head[N];
  int tail[N];
  logic [N-1:0] hs_seen = '0;

  task automatic push(input int r, input int a, input int b);
    ja[r][tail[r] % 8] = W'(a);
    jb[r][tail[r] % 8] = W'(b);
    tail[r]++;
  endtask

  always @(posedge clk_i) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (hs_seen[i]) head[i]++;
      req_valid_i[i]       = (head[i] != tail[i]);
      req_a_i[i*W +: W]    = ja[i][head[i] % 8];
      req_b_i[i*W +: W]    = jb[i][head[i] % 8];
    end
  end

  // Engine stand-in: done after eng_lat enabled cycles (0 = never).
  int ecnt = 0;
  int eng_lat = 5;
  bit spurious = 1'b0;
  always @(posedge clk_i) begin
    #1;
    if (eng_enable_o) ecnt++; else ecnt = 0;
    eng_done_i   = eng_enable_o ? (eng_lat != 0 && ecnt == eng_lat) : spurious;
    eng_result_i = eng_enable_o ? gcd_f(eng_a_o, eng_b_o) : 8'hA5;
  end

  // Job-level reference model and per-cycle compare.
  typedef struct {
    int id; int res; int err; int hs; int start; int en;
  } rsp_rec_t;
  rsp_rec_t rsp_log[$];
  int       grant_log[$];

  int m_phase = 0;   // 0 waiting for a job, 1 engine working, 2 answer pending
  int m_ptr = 0, m_id = 0, m_run = 0, m_hs = 0, m_start = 0, m_en = 0;
  logic [W-1:0] m_a, m_b, m_res;
  logic m_err;

  always @(negedge clk_i) begin
    logic [N-1:0] exp_gnt;
    int g;
    rsp_rec_t rec;
    cyc++;
    hs_seen = '0;
    if (!nreset_i) begin
      m_phase = 0; m_ptr = 0;
      check("rst_eng_enable", eng_enable_o, 0);
      check("rst_rsp_valid",  rsp_valid_o, 0);
      check("rst_busy",       busy_o, 0);
      check("rst_eng_a",      eng_a_o, 0);
      check("rst_rsp_result", rsp_result_o, 0);
    end else begin
      exp_gnt = '0; g = -1;
      if (m_phase == 0)
        for (int k = 0; k < N; k++)
          if (g < 0 && req_valid_i[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      if (g >= 0) exp_gnt[g] = 1'b1;
      check("ready_onehot", $onehot0(req_ready_o), 1);
      check("req_ready",    req_ready_o, exp_gnt);
      check("eng_enable",   eng_enable_o, m_phase == 1);
      check("busy",         busy_o, m_phase != 0);
      check("rsp_valid",    rsp_valid_o, m_phase == 2);
      if (m_phase == 1) begin
        check("eng_a", eng_a_o, m_a);
        check("eng_b", eng_b_o, m_b);
      end
      if (m_phase == 2) begin
        check("rsp_id",     rsp_id_o, m_id);
        check("rsp_result", rsp_result_o, m_res);
        check("rsp_error",  rsp_error_o, m_err);
      end
      case (m_phase)
        0: if (g >= 0) begin
          hs_seen[g] = 1'b1;
          grant_log.push_back(g);
          m_id = g; m_hs = cyc; m_en = 0;
          m_a = req_a_i[g*W +: W];
          m_b = req_b_i[g*W +: W];
          if (m_a == 0 || m_b == 0) begin
            m_res = m_a | m_b; m_err = 1'b0; m_phase = 2; m_start = cyc + 1;
          end else begin
            m_run = 0; m_phase = 1;
          end
        end
        1: begin
          m_en++; m_run++;
          if (eng_done_i === 1'b1) begin
            m_res = gcd_f(m_a, m_b); m_err = 1'b0; m_phase = 2; m_start = cyc + 1;
          end else if (m_run == TO) begin
            m_res = '0; m_err = 1'b1; m_phase = 2; m_start = cyc + 1;
          end
        end
        default: if (rsp_ready_i) begin
          rec.id = m_id; rec.res = int'(m_res); rec.err = int'(m_err);
          rec.hs = m_hs; rec.start = m_start; rec.en = m_en;
          rsp_log.push_back(rec);
          m_ptr = (m_id + 1) % N;
          m_phase = 0;
        end
      endcase
    end
  end

  function automatic bit all_drained();
    for (int i = 0; i < N; i++) if (head[i] != tail[i]) return 1'b0;
    return (req_valid_i == '0) && (m_phase == 0);
  endfunction

  task automatic wait_idle(input string nm, input int maxc);
    int c;
    c = 0;
    while (!(all_drained() && !busy_o) && c < maxc) begin
      @(posedge clk_i); #3; c++;
    end
    check({nm, "_timely"}, c < maxc, 1);
  endtask

  task automatic last_rsp(input string nm, input int back, input int id,
                          input int res, input int err);
    int n;
    n = rsp_log.size();
    if (n <= back) check({nm, "_logged"}, n, back + 1);
    else begin
      check({nm, "_id"},  rsp_log[n-1-back].id, id);
      check({nm, "_res"}, rsp_log[n-1-back].res, res);
      check({nm, "_err"}, rsp_log[n-1-back].err, err);
    end
  endtask

  task automatic do_reset();
    nreset_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #3 nreset_i = 1'b1;
  endtask

  initial begin
    #(CP * 20000);
    $display("FAIL global_timeout: simulation still running at cycle %0d", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    int g0, n, c;
    #1 nreset_i = 1'b0;
    #1;
    check("t1_rsp_valid", rsp_valid_o, 0);
    check("t1_eng_en",    eng_enable_o, 0);
    check("t1_busy",      busy_o, 0);
    check("t1_rsp_res",   rsp_result_o, 0);
    @(posedge clk_i); @(posedge clk_i);
    #3 nreset_i = 1'b1;
    @(posedge clk_i); #3;
    check("t1_ready_idle", req_ready_o, 0);

    // Single engine job.
    eng_lat = 5;
    push(2, 12, 18);
    wait_idle("t2", 100);
    last_rsp("t2", 0, 2, 6, 0);
    n = rsp_log.size();
    if (n > 0) check("t2_enable_cycles", rsp_log[n-1].en, 5);

    // All requesters busy after reset: strict rotation.
    do_reset();
    eng_lat = 2;
    g0 = grant_log.size();
    for (int i = 0; i < N; i++) begin
      push(i, 6 * (i + 1), 4 * (i + 1));
      push(i, 6 * (i + 1), 4 * (i + 1));
    end
    wait_idle("t3", 300);
    if (grant_log.size() < g0 + 5) check("t3_grants", grant_log.size(), g0 + 5);
    else for (int k = 0; k < 5; k++) check("t3_order", grant_log[g0 + k], k % 4);
    last_rsp("t3", 0, 3, 8, 0);

    // Zero-operand bypass.
    eng_lat = 5;
    push(1, 0, 9);
    wait_idle("t4a", 50);
    last_rsp("t4a", 0, 1, 9, 0);
    n = rsp_log.size();
    if (n > 0) begin
      check("t4a_latency", rsp_log[n-1].start - rsp_log[n-1].hs, 1);
      check("t4a_no_engine", rsp_log[n-1].en, 0);
    end
    push(3, 0, 0);
    wait_idle("t4b", 50);
    last_rsp("t4b", 0, 3, 0, 0);
    push(0, 7, 0);
    wait_idle("t4c", 50);
    last_rsp("t4c", 0, 0, 7, 0);

    // Watchdog abort, then a normal job.
    eng_lat = 0;
    push(0, 5, 10);
    wait_idle("t5a", 100);
    last_rsp("t5a", 0, 0, 0, 1);
    n = rsp_log.size();
    if (n > 0) begin
      check("t5a_abort_time", rsp_log[n-1].start - rsp_log[n-1].hs, 1 + TO);
      check("t5a_run_cycles", rsp_log[n-1].en, TO);
    end
    eng_lat = 3;
    push(1, 9, 6);
    wait_idle("t5b", 100);
    last_rsp("t5b", 0, 1, 3, 0);

    // Backpressure with stray done pulses.
    rsp_ready_i = 1'b0;
    spurious = 1'b1;
    push(2, 0, 4);
    repeat (3) begin @(posedge clk_i); #3; end
    g0 = grant_log.size();
    eng_lat = 4;
    push(3, 15, 10);
    repeat (10) begin
      @(posedge clk_i); #3;
      check("t6_hold_valid",  rsp_valid_o, 1);
      check("t6_hold_result", rsp_result_o, 4);
      check("t6_hold_id",     rsp_id_o, 2);
      check("t6_no_ready",    req_ready_o, 0);
    end
    check("t6_no_grant", grant_log.size(), g0);
    spurious = 1'b0;
    rsp_ready_i = 1'b1;
    wait_idle("t6", 100);
    last_rsp("t6_first", 1, 2, 4, 0);
    last_rsp("t6_second", 0, 3, 5, 0);

    // Reset in the middle of an engine job.
    eng_lat = 2;
    push(1, 0, 3);
    wait_idle("t7a", 50);
    eng_lat = 0;
    push(2, 8, 12);
    c = 0;
    while (!eng_enable_o && c < 10) begin @(posedge clk_i); #3; c++; end
    check("t7_run_entered", eng_enable_o, 1);
    push(0, 1, 1);
    push(3, 2, 4);
    repeat (3) begin @(posedge clk_i); #3; end
    g0 = grant_log.size();
    nreset_i = 1'b0;
    #1;
    check("t7_async_enable", eng_enable_o, 0);
    check("t7_async_busy",   busy_o, 0);
    check("t7_async_eng_a",  eng_a_o, 0);
    check("t7_async_eng_b",  eng_b_o, 0);
    eng_lat = 2;
    repeat (2) @(posedge clk_i);
    #3 nreset_i = 1'b1;
    wait_idle("t7", 100);
    if (grant_log.size() < g0 + 2) check("t7_grants", grant_log.size(), g0 + 2);
    else begin
      check("t7_first_grant",  grant_log[g0], 0);
      check("t7_second_grant", grant_log[g0 + 1], 3);
    end
    last_rsp("t7", 0, 3, 2, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
